blaster_uart_tx: RTL and testbench

Parametrised UART transmitter for the blaster UART path. It buffers bytes in an internal FIFO and serialises them LSB-first onto `o_tx_pin`, with configurable data width, stop-bit count and optional parity. Back-to-back frames go out with no idle gap. Upstream logic writes through a valid/ready handshake.

---
 rtl/blaster_uart_pkg.sv | 28 ++
 rtl/blaster_uart_fifo.sv | 52 +++++
 rtl/blaster_uart_tx.sv | 154 +++++++++++++++
 tb/tb_blaster_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blaster_uart_pkg.sv
// Shared types and helpers for the blaster UART transmit path.
// Parity support is compiled in with the BLASTER_UART_TX_PARITY_EN macro.
package blaster_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PARITY_EVEN    = 1'b0;
  localparam logic PARITY_ODD_SEL = 1'b1;

`ifdef BLASTER_UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Whole frame duration in clock cycles: start, data, optional parity, stop.
  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int stop_bits);
    return (1 + data_bits + PARITY_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/blaster_uart_fifo.sv
// Synchronous FIFO with occupancy count, full/empty flags and async active-high reset.
module blaster_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/blaster_uart_tx.sv
// Buffered UART transmitter: FIFO front end feeding an LSB-first serialiser FSM.
// Optional parity bit is enabled by defining BLASTER_UART_TX_PARITY_EN.
module blaster_uart_tx
  import blaster_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          i_clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_in,
  output logic                          o_ready,
  output logic                          o_tx_pin,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [TW-1:0]        bit_timer;
  logic                 stop_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;
  logic                 frame_end;
`ifdef BLASTER_UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign bit_end   = (bit_timer == TW'(CLKS_PER_BIT - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end = (state == STOP) && bit_end && last_stop;
  assign pop       = !empty && ((state == IDLE) || frame_end);
  assign o_ready   = !full;

  blaster_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .reset   (reset),
    .push    (i_valid),
    .wr_data (i_in),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (o_fifo_count)
  );

  // The shift register is pre-shifted so its LSB always holds the next data bit.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_timer  <= '0;
      stop_cnt   <= 1'b0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      o_tx_pin   <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef BLASTER_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      o_done    <= 1'b0;
      bit_timer <= (state == IDLE || bit_end) ? '0 : bit_timer + 1'b1;
      if (pop) begin
        shift_reg <= head;
`ifdef BLASTER_UART_TX_PARITY_EN
        parity_bit <= (^head) ^ ((PARITY_ODD != 0) ? PARITY_ODD_SEL : PARITY_EVEN);
`endif
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            state    <= START;
            o_tx_pin <= 1'b0;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            bit_idx   <= '0;
            o_tx_pin  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef BLASTER_UART_TX_PARITY_EN
              state    <= PARITY;
              o_tx_pin <= parity_bit;
`else
              state    <= STOP;
              stop_cnt <= 1'b0;
              o_tx_pin <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              o_tx_pin  <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef BLASTER_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            o_tx_pin <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              o_done <= 1'b1;
              if (!empty) begin
                state    <= START;
                o_tx_pin <= 1'b0;
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          o_tx_pin <= 1'b1;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blaster_uart_tx.sv
// Self-checking bench for blaster_uart_tx: two configurations checked every cycle
// against a frame-level reference model (line levels expanded from queued words).
module tb_blaster_uart_tx;
  import blaster_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef BLASTER_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       valid_in = 1'b0;
  logic [8:0] data_in = '0;

  logic       ready_a, tx_a, busy_a, done_a;
  logic [2:0] cnt_a;
  logic       ready_b, tx_b, busy_b, done_b;
  logic [2:0] cnt_b;
  logic       valid_a, valid_b;
  logic [7:0] in_a;
  logic [4:0] in_b;

  logic       obs_tx, obs_busy, obs_done, obs_ready;
  logic [2:0] obs_count;

  int compared = 0;
  int failed = 0;
  int done_seen = 0;
  int accepted = 0;
  int lat;

  logic [8:0] mq[$];
  logic       ml[$];
  logic       exp_done = 1'b0;

  always #5 clk = ~clk;

  assign valid_a = valid_in && !sel;
  assign valid_b = valid_in && sel;
  assign in_a    = data_in[7:0];
  assign in_b    = data_in[4:0];

  assign obs_tx    = sel ? tx_b    : tx_a;
  assign obs_busy  = sel ? busy_b  : busy_a;
  assign obs_done  = sel ? done_b  : done_a;
  assign obs_ready = sel ? ready_b : ready_a;
  assign obs_count = sel ? cnt_b   : cnt_a;

  blaster_uart_tx #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (1),
    .FIFO_DEPTH (DEPTH), .PARITY_ODD (1)
  ) dut_a (
    .i_clk (clk), .reset (reset), .i_valid (valid_a), .i_in (in_a),
    .o_ready (ready_a), .o_tx_pin (tx_a), .o_busy (busy_a),
    .o_done (done_a), .o_fifo_count (cnt_a)
  );

  blaster_uart_tx #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (5), .STOP_BITS (2),
    .FIFO_DEPTH (DEPTH), .PARITY_ODD (0)
  ) dut_b (
    .i_clk (clk), .reset (reset), .i_valid (valid_b), .i_in (in_b),
    .o_ready (ready_b), .o_tx_pin (tx_b), .o_busy (busy_b),
    .o_done (done_b), .o_fifo_count (cnt_b)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    ml.delete();
    exp_done = 1'b0;
  endtask

  // Expand one word into the per-cycle line levels of its frame.
  task automatic buildFrame(input logic [8:0] w);
    int  db, sb, podd;
    logic p;
    db   = sel ? 5 : 8;
    sb   = sel ? 2 : 1;
    podd = sel ? 0 : 1;
    p    = podd[0];
    repeat (CPB) ml.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      p = p ^ w[i];
      repeat (CPB) ml.push_back(w[i]);
    end
    if (PAR == 1) repeat (CPB) ml.push_back(p);
    repeat (sb * CPB) ml.push_back(1'b1);
  endtask

  task automatic modelEdge(input logic v, input logic [8:0] din);
    logic r;
    r = (mq.size() < DEPTH);
    exp_done = (ml.size() == 1);
    if (ml.size() > 0) void'(ml.pop_front());
    if (ml.size() == 0 && mq.size() > 0) buildFrame(mq.pop_front());
    if (v && r) mq.push_back(din);
  endtask

  task automatic checkOutput();
    cmp("tx",    {31'd0, obs_tx},    {31'd0, (ml.size() > 0) ? ml[0] : 1'b1});
    cmp("busy",  {31'd0, obs_busy},  {31'd0, ml.size() > 0});
    cmp("done",  {31'd0, obs_done},  {31'd0, exp_done});
    cmp("count", {29'd0, obs_count}, mq.size());
    cmp("ready", {31'd0, obs_ready}, {31'd0, mq.size() < DEPTH});
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] d);
    valid_in = v;
    data_in  = d;
    if (v && obs_ready) accepted++;
    @(posedge clk);
    modelEdge(v, d);
    #1;
    if (obs_done === 1'b1) done_seen++;
    checkOutput();
  endtask

  task automatic waitDone(output int l);
    l = -1;
    for (int k = 1; k <= 400; k++) begin
      applyStimulus(1'b0, 9'd0);
      if (obs_done === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max && (mq.size() != 0 || ml.size() != 0); k++)
      applyStimulus(1'b0, 9'd0);
    applyStimulus(1'b0, 9'd0);
    cmp("drain_idle", {31'd0, obs_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values.
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b0;
    applyStimulus(1'b0, 9'd0);

    // Single frame 0xA5 with done latency from the accepting edge.
    applyStimulus(1'b1, 9'h0A5);
    waitDone(lat);
    cmp("single_latency", lat, frame_cycles(CPB, 8, 1) + 1);
    drain(200);

    // Back-to-back: three writes while a frame is already on the line.
    done_seen = 0;
    applyStimulus(1'b1, 9'h03C);
    repeat (4) applyStimulus(1'b0, 9'd0);
    applyStimulus(1'b1, 9'h000);
    cmp("b2b_count1", {29'd0, obs_count}, 32'd1);
    applyStimulus(1'b1, 9'h0FF);
    cmp("b2b_count2", {29'd0, obs_count}, 32'd2);
    applyStimulus(1'b1, 9'h055);
    cmp("b2b_count3", {29'd0, obs_count}, 32'd3);
    drain(400);
    cmp("b2b_done_pulses", done_seen, 32'd4);

    // Full FIFO: hold valid for 10 cycles from idle.
    done_seen = 0;
    accepted  = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 9'($urandom));
    cmp("full_accepted", accepted, 32'd5);
    cmp("full_ready_low", {31'd0, obs_ready}, 32'd0);
    drain(600);
    cmp("full_done_pulses", done_seen, 32'd5);

    // Parity bit of 0x07 on the odd-parity configuration.
    applyStimulus(1'b1, 9'h007);
    repeat (37) applyStimulus(1'b0, 9'd0);
`ifdef BLASTER_UART_TX_PARITY_EN
    cmp("parity_odd_bit", {31'd0, obs_tx}, 32'd0);
`else
    cmp("stop_after_data", {31'd0, obs_tx}, 32'd1);
`endif
    drain(200);

    // Switch to the 5-bit / 2-stop / even-parity configuration.
    sel = 1'b1;
    applyStimulus(1'b0, 9'd0);
    applyStimulus(1'b1, 9'h007);
    repeat (25) applyStimulus(1'b0, 9'd0);
    cmp("parity_even_bit", {31'd0, obs_tx}, 32'd1);
    drain(200);
    applyStimulus(1'b1, 9'h01F);
    waitDone(lat);
    cmp("ext_latency", lat, frame_cycles(CPB, 5, 2) + 1);
    drain(200);

    // Reset in the middle of data bit 3, then a clean frame.
    applyStimulus(1'b1, 9'h00A);
    repeat (18) applyStimulus(1'b0, 9'd0);
    #2 reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b0;
    applyStimulus(1'b1, 9'h013);
    waitDone(lat);
    cmp("post_reset_latency", lat, frame_cycles(CPB, 5, 2) + 1);
    drain(200);

    // Randomised traffic on both configurations.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      applyStimulus(1'b0, 9'd0);
      for (int i = 0; i < 700; i++)
        applyStimulus(($urandom_range(0, 3) == 0), 9'($urandom));
      drain(600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
